// File: rtl/cpu_params_pkg.sv
// Shared CPU parameters: register width, machine-timer MMR offsets and controller state type.
package cpu_params_pkg;

  localparam int RSZ     = 32;
  localparam int NUM_MMR = 5;

  localparam logic [7:0] MMR_MTIME_LO    = 8'h00;
  localparam logic [7:0] MMR_MTIME_HI    = 8'h04;
  localparam logic [7:0] MMR_MTIMECMP_LO = 8'h08;
  localparam logic [7:0] MMR_MTIMECMP_HI = 8'h0C;
  localparam logic [7:0] MMR_MSIP        = 8'h10;

  // Bit positions in the one-hot select produced by the address decoder.
  localparam int SEL_MTIME_LO    = 0;
  localparam int SEL_MTIME_HI    = 1;
  localparam int SEL_MTIMECMP_LO = 2;
  localparam int SEL_MTIMECMP_HI = 3;
  localparam int SEL_MSIP        = 4;

  typedef enum logic [1:0] {MMR_IDLE, MMR_EXEC, MMR_ACK} mmr_state_t;

endpackage

// File: rtl/mmr_addr_dec.sv
// Combinational decoder for a word-aligned 5-register MMR window: one-hot select plus error flag.
module mmr_addr_dec
  import cpu_params_pkg::*;
#(
  parameter logic [31:0] MMR_BASE = 32'hFFFF_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [NUM_MMR-1:0] sel,
  output logic               err
);

  logic [ADDR_W-1:0] off;
  logic              in_range;

  always_comb begin
    off      = addr - ADDR_W'(MMR_BASE);
    // Checking the offset rather than BASE+0x10 keeps the window correct near address wrap.
    in_range = (addr >= ADDR_W'(MMR_BASE)) && (off <= ADDR_W'(MMR_MSIP));
    err      = !in_range || (addr[1:0] != 2'b00);
    sel      = '0;
    if (!err) begin
      case (off[4:2])
        3'd0:    sel[SEL_MTIME_LO]    = 1'b1;
        3'd1:    sel[SEL_MTIME_HI]    = 1'b1;
        3'd2:    sel[SEL_MTIMECMP_LO] = 1'b1;
        3'd3:    sel[SEL_MTIMECMP_HI] = 1'b1;
        3'd4:    sel[SEL_MSIP]        = 1'b1;
        default: sel = '0;
      endcase
    end
  end

endmodule

// File: rtl/mmr_ctrl.sv
// Bus-side controller for the machine-timer MMR block: IDLE -> EXEC -> ACK per request.
// Optional MMR_SNAPSHOT_EN: reading mtime lo latches mtime hi so a lo/hi read pair is carry-consistent.
module mmr_ctrl
  import cpu_params_pkg::*;
#(
  parameter logic [31:0] MMR_BASE = 32'hFFFF_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              mmr_req,
  input  logic              mmr_rw,
  input  logic [ADDR_W-1:0] mmr_addr,
  input  logic [RSZ-1:0]    mmr_wr_data,
  output logic              mmr_busy,
  output logic              mmr_ack,
  output logic              mmr_err,
  output logic [RSZ-1:0]    mmr_rd_data,
  output logic [RSZ-1:0]    irq_wr_data,
  output logic              mtime_lo_wr,
  output logic              mtime_hi_wr,
  output logic              mtimecmp_lo_wr,
  output logic              mtimecmp_hi_wr,
  output logic              msip_wr,
  input  logic [2*RSZ-1:0]  mtime,
  input  logic [2*RSZ-1:0]  mtimecmp,
  input  logic [RSZ-1:0]    msip_reg
);

  mmr_state_t        state_q, state_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RSZ-1:0]    wdata_q, wdata_d;
  logic [RSZ-1:0]    rd_data_q, rd_data_d;
  logic [RSZ-1:0]    snap_q, snap_d;

  logic [NUM_MMR-1:0] sel;
  logic               dec_err;
  logic [NUM_MMR-1:0] wr_stb;
  logic [RSZ-1:0]     rd_mux;

  mmr_addr_dec #(.MMR_BASE(MMR_BASE), .ADDR_W(ADDR_W)) u_dec (
    .addr (addr_q),
    .sel  (sel),
    .err  (dec_err)
  );

  always_comb begin
    rd_mux = '0;
    case (1'b1)
      sel[SEL_MTIME_LO]:    rd_mux = mtime[RSZ-1:0];
`ifdef MMR_SNAPSHOT_EN
      sel[SEL_MTIME_HI]:    rd_mux = snap_q;
`else
      sel[SEL_MTIME_HI]:    rd_mux = mtime[2*RSZ-1:RSZ];
`endif
      sel[SEL_MTIMECMP_LO]: rd_mux = mtimecmp[RSZ-1:0];
      sel[SEL_MTIMECMP_HI]: rd_mux = mtimecmp[2*RSZ-1:RSZ];
      sel[SEL_MSIP]:        rd_mux = msip_reg;
      default:              rd_mux = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    snap_d    = snap_q;
    case (state_q)
      MMR_IDLE: begin
        if (mmr_req) begin
          rw_d    = mmr_rw;
          addr_d  = mmr_addr;
          wdata_d = mmr_wr_data;
          state_d = MMR_EXEC;
        end
      end
      MMR_EXEC: begin
        state_d = MMR_ACK;
        if (dec_err)    rd_data_d = '0;
        else if (!rw_q) rd_data_d = rd_mux;
`ifdef MMR_SNAPSHOT_EN
        if (!dec_err && !rw_q && sel[SEL_MTIME_LO])
          snap_d = mtime[2*RSZ-1:RSZ];
        if (!dec_err && rw_q && (sel[SEL_MTIME_LO] || sel[SEL_MTIME_HI]))
          snap_d = '0;
`endif
      end
      MMR_ACK:  state_d = MMR_IDLE;
      default:  state_d = MMR_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q   <= MMR_IDLE;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      snap_q    <= '0;
    end else begin
      state_q   <= state_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      snap_q    <= snap_d;
    end
  end

  // The decoder's select is one-hot, so gating it with EXEC/write keeps strobes exclusive.
  assign wr_stb = (state_q == MMR_EXEC && rw_q && !dec_err) ? sel : '0;

  assign mtime_lo_wr    = wr_stb[SEL_MTIME_LO];
  assign mtime_hi_wr    = wr_stb[SEL_MTIME_HI];
  assign mtimecmp_lo_wr = wr_stb[SEL_MTIMECMP_LO];
  assign mtimecmp_hi_wr = wr_stb[SEL_MTIMECMP_HI];
  assign msip_wr        = wr_stb[SEL_MSIP];

  assign mmr_busy    = (state_q == MMR_EXEC) || (state_q == MMR_ACK);
  assign mmr_ack     = (state_q == MMR_ACK);
  assign mmr_err     = (state_q == MMR_ACK) && dec_err;
  assign mmr_rd_data = rd_data_q;
  assign irq_wr_data = wdata_q;

endmodule
